// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between the CPU
// execute path (port 0) and the DMA address/length engine (port 1).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy,
  output logic [1:0]       fsm_state
);
  // Handshakes: a request moves on an edge where req_valid[i] & req_ready[i];
  // a response moves on an edge where resp_valid[i] & resp_ready[i]. Only the
  // port granted for the current operation is ever looked at on the response side.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             gnt_id;
  logic             id_q;
  logic             illegal_q;
  logic             accept;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_illegal;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_id = ptr;
    case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = ptr;
    endcase
  end

  always_comb begin
    sel_op      = gnt_id ? req_op1 : req_op0;
    sel_a       = gnt_id ? req_a1  : req_a0;
    sel_b       = gnt_id ? req_b1  : req_b0;
    sel_illegal = (sel_op == 3'b010) || (sel_op == 3'b101) || (sel_op == 3'b111);
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          accept    = 1'b1;
          req_ready = gnt_id ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (resp_ready[id_q]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      id_q       <= 1'b0;
      illegal_q  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_funct  <= 3'b000;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a     <= sel_a;
        alu_b     <= sel_b;
        alu_funct <= sel_illegal ? 3'b000 : sel_op;
        illegal_q <= sel_illegal;
        id_q      <= gnt_id;
        ptr       <= ~gnt_id;
      end
      // Illegal ops still run through the ALU as an add; the result is discarded.
      if (state == EXEC) begin
        resp_data  <= illegal_q ? '0 : alu_result;
        resp_err   <= illegal_q;
        resp_valid <= id_q ? 2'b10 : 2'b01;
      end else if ((state == RESP) && resp_ready[id_q]) begin
        resp_valid <= 2'b00;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: transaction-level model with an
// expected-result queue, a per-cycle compare process and literal spot checks.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [2:0]   req_op0 = 3'b000, req_op1 = 3'b000;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_funct;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready = 2'b00;
  logic [W-1:0] resp_data;
  logic         resp_err;
  logic         busy;
  logic [1:0]   fsm_state;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .fsm_state(fsm_state)
  );

  function automatic logic [W-1:0] golden(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd6:    return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd5) || (op == 3'd7);
  endfunction

  // Stand-in for the shared ALU instance.
  always_comb alu_result = golden(alu_funct, alu_a, alu_b);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  int           m_age = 0;       // cycles since the current op was accepted, 0 = none
  logic         m_ptr = 1'b0;
  logic         m_id = 1'b0;
  logic         m_rst = 1'b1;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [2:0]   m_funct = 3'b000;
  logic [W-1:0] exp_q[$];
  logic         err_q[$];

  function automatic logic model_grant();
    if (req_valid == 2'b01) return 1'b0;
    if (req_valid == 2'b10) return 1'b1;
    return m_ptr;
  endfunction

  always @(posedge clk) begin : model
    logic       g;
    logic [2:0] op;
    m_rst = !rst_n;
    if (!rst_n) begin
      m_age = 0; m_ptr = 1'b0; m_id = 1'b0;
      m_a = '0; m_b = '0; m_funct = 3'b000;
      exp_q.delete(); err_q.delete();
    end else if (m_age == 0) begin
      if (req_valid != 2'b00) begin
        g  = model_grant();
        op = g ? req_op1 : req_op0;
        m_a = g ? req_a1 : req_a0;
        m_b = g ? req_b1 : req_b0;
        m_funct = is_illegal(op) ? 3'b000 : op;
        exp_q.push_back(is_illegal(op) ? '0 : golden(op, m_a, m_b));
        err_q.push_back(is_illegal(op));
        m_id = g; m_ptr = ~g; m_age = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (resp_ready[m_id]) begin
      m_age = 0;
      void'(exp_q.pop_front());
      void'(err_q.pop_front());
    end
  end

  always @(negedge clk) begin : cmp
    logic [1:0] exp_rdy;
    exp_rdy = 2'b00;
    if (rst_n && (m_age == 0) && (req_valid != 2'b00)) exp_rdy = model_grant() ? 2'b10 : 2'b01;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_age != 0);
    chk("resp_valid", resp_valid, (m_age >= 2) ? (m_id ? 2'b10 : 2'b01) : 2'b00);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_funct", alu_funct, m_funct);
    if (m_age >= 2 && exp_q.size() > 0) begin
      chk("resp_data", resp_data, exp_q[0]);
      chk("resp_err", resp_err, err_q[0]);
    end
    if (m_rst) begin
      chk("rst_resp_data", resp_data, '0);
      chk("rst_resp_err", resp_err, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int port, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (port == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else           begin req_op1 = op; req_a1 = a; req_b1 = b; end
    req_valid[port] = 1'b1;
  endtask

  task automatic wait_accept(input int port, input string name);
    int cnt = 0;
    do begin @(negedge clk); cnt++; end while (!req_ready[port] && cnt < TO);
    if (!req_ready[port]) begin
      n_vec++; n_err++;
      $display("FAIL %s: request not accepted within %0d cycles", name, TO);
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
  endtask

  task automatic wait_resp(input int port, input logic [W-1:0] d, input logic e,
                           input string name, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!resp_valid[port] && cyc < TO);
    if (!resp_valid[port]) begin
      n_vec++; n_err++;
      $display("FAIL %s: no response within %0d cycles", name, TO);
    end else begin
      chk({name, "_data"}, resp_data, d);
      chk({name, "_err"}, resp_err, e);
    end
  endtask

  task automatic run_op(input int port, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] d, input logic e,
                        input string name);
    int cyc;
    @(posedge clk); #1;
    resp_ready = 2'b11;
    set_req(port, op, a, b);
    wait_accept(port, name);
    wait_resp(port, d, e, name, cyc);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0]   obs_v[$];
  logic [W-1:0] obs_d[$];
  logic [1:0]   exp_v[4];
  logic [W-1:0] exp_d[4];

  initial begin : stim
    int cyc;
    exp_v = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_d = '{32'hFF, 32'd7, 32'hFF, 32'd7};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_resp_valid", resp_valid, 2'b00);
    chk("reset_resp_data", resp_data, '0);
    chk("reset_alu_a", alu_a, '0);
    chk("reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", req_ready, 2'b00);

    // CPU add 5+7 with a fixed two-cycle response latency
    @(posedge clk); #1;
    resp_ready = 2'b01;
    set_req(0, 3'b000, 32'd5, 32'd7);
    @(negedge clk);
    chk("idle_port0_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, 32'd12, 1'b0, "cpu_add", cyc);
    chk("cpu_add_latency", cyc, 2);
    @(negedge clk);
    chk("cpu_add_idle", busy, 1'b0);

    // Both ports valid continuously: grants alternate starting from port 1
    @(posedge clk); #1;
    resp_ready = 2'b11;
    set_req(0, 3'b001, 32'd10, 32'd3);
    set_req(1, 3'b100, 32'hF0, 32'h0F);
    repeat (12) begin
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        obs_v.push_back(resp_valid);
        obs_d.push_back(resp_data);
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("contention_count", obs_v.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("contention_port", (i < obs_v.size()) ? obs_v[i] : 2'b00, exp_v[i]);
      chk("contention_data", (i < obs_d.size()) ? obs_d[i] : '0, exp_d[i]);
    end

    // Backpressure on port 1; port 0's ready must be ignored, port 0 request waits
    @(posedge clk); #1;
    resp_ready = 2'b01;
    set_req(1, 3'b110, 32'd0, 32'd0);
    wait_accept(1, "nor_accept");
    set_req(0, 3'b111, 32'd1, 32'd1);
    wait_resp(1, 32'hFFFF_FFFF, 1'b0, "nor", cyc);
    repeat (5) begin
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 2'b10);
      chk("bp_resp_data", resp_data, 32'hFFFF_FFFF);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    wait_accept(0, "illegal_accept");
    wait_resp(0, '0, 1'b1, "illegal", cyc);
    chk("illegal_funct", alu_funct, 3'b000);

    run_op(1, 3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, "dma_and");
    run_op(0, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, "cpu_add_wrap");
    run_op(1, 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, "dma_sub_neg");
    run_op(0, 3'b100, 32'hA500_0000, 32'h0000_005A, 32'hA500_005A, 1'b0, "cpu_or");
    run_op(1, 3'b110, 32'h0F0F_0F0F, 32'h3030_3030, 32'hC0C0_C0C0, 1'b0, "dma_nor");

    // Request withdrawn before any edge sees it
    @(posedge clk); #1;
    set_req(1, 3'b000, 32'd9, 32'd9);
    @(negedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("glitch_idle", busy, 1'b0);

    // Reset during EXEC abandons the op and returns the pointer to port 0
    @(posedge clk); #1;
    set_req(0, 3'b000, 32'd1, 32'd1);
    wait_accept(0, "abandon_accept");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abandon_resp_valid", resp_valid, 2'b00);
    chk("abandon_busy", busy, 1'b0);
    chk("abandon_resp_data", resp_data, '0);
    @(posedge clk); #1;
    resp_ready = 2'b11;
    set_req(0, 3'b000, 32'd20, 32'd22);
    set_req(1, 3'b001, 32'd50, 32'd9);
    @(negedge clk);
    chk("ptr_after_reset", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, 32'd42, 1'b0, "post_reset_cpu", cyc);
    wait_accept(1, "post_reset_dma");
    wait_resp(1, 32'd41, 1'b0, "post_reset_dma", cyc);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
